// File: rtl/pipeline_move_ctrl.sv
// Global advance controller for the 5-stage rv32i pipeline: issues imem/dmem requests,
// waits for their responses and produces the move/flush strobes. Optional perf counters: PIPE_PERF_CNT_EN.
module pipeline_move_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req_valid,
  input  logic        dmem_req_valid,
  input  logic        imem_resp,
  input  logic        dmem_resp,
  input  logic        flush_req,
  output logic        imem_issue,
  output logic        dmem_issue,
  output logic        move,
  output logic        flush,
  output logic        busy,
  output logic        timeout_err,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_moves,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes,
`endif
  output logic        spurious_err
);

  typedef enum logic {ST_ISSUE = 1'b0, ST_WAIT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             got_i_q, got_i_d;
  logic             got_d_q, got_d_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             spurious_err_q, spurious_err_d;
  logic             issue_i_s, issue_d_s, move_s, flush_s, spur_s, done_s;

  // Next-state and strobe decode
  always_comb begin
    state_d      = state_q;
    got_i_d      = got_i_q;
    got_d_d      = got_d_q;
    flush_pend_d = flush_pend_q;
    cnt_d        = cnt_q;
    issue_i_s    = 1'b0;
    issue_d_s    = 1'b0;
    move_s       = 1'b0;
    flush_s      = 1'b0;
    spur_s       = 1'b0;
    done_s       = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        issue_i_s    = imem_req_valid;
        issue_d_s    = dmem_req_valid;
        got_i_d      = ~imem_req_valid;
        got_d_d      = ~dmem_req_valid;
        flush_pend_d = flush_req;
        cnt_d        = '0;
        spur_s       = imem_resp | dmem_resp;
        if (!imem_req_valid && !dmem_req_valid) begin
          move_s  = 1'b1;
          flush_s = flush_req;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response for a slot that is already satisfied is reported and dropped.
        spur_s       = (imem_resp & got_i_q) | (dmem_resp & got_d_q);
        done_s       = (got_i_q | imem_resp) & (got_d_q | dmem_resp);
        cnt_d        = (cnt_q == TMO) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (done_s) begin
          move_s       = 1'b1;
          flush_s      = flush_pend_q | flush_req;
          got_i_d      = 1'b0;
          got_d_d      = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = ST_ISSUE;
        end else begin
          got_i_d      = got_i_q | imem_resp;
          got_d_d      = got_d_q | dmem_resp;
          flush_pend_d = flush_pend_q | flush_req;
          state_d      = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
    timeout_err_d  = timeout_err_q | ((state_q == ST_WAIT) && (cnt_d == TMO));
    spurious_err_d = spurious_err_q | spur_s;
  end

  // Control state and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ISSUE;
      got_i_q        <= 1'b0;
      got_d_q        <= 1'b0;
      flush_pend_q   <= 1'b0;
      cnt_q          <= '0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      got_i_q        <= got_i_d;
      got_d_q        <= got_d_d;
      flush_pend_q   <= flush_pend_d;
      cnt_q          <= cnt_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
    end
  end

  // Strobes are gated by rst so every output drops as soon as reset asserts.
  assign imem_issue   = issue_i_s & ~rst;
  assign dmem_issue   = issue_d_s & ~rst;
  assign move         = move_s & ~rst;
  assign flush        = flush_s & ~rst;
  assign busy         = (state_q == ST_WAIT) & ~rst;
  assign timeout_err  = timeout_err_q;
  assign spurious_err = spurious_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_moves_q, perf_stall_q, perf_flushes_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_moves_q   <= 32'd0;
      perf_stall_q   <= 32'd0;
      perf_flushes_q <= 32'd0;
    end else begin
      perf_moves_q   <= perf_moves_q + {31'd0, move_s};
      perf_stall_q   <= perf_stall_q + {31'd0, (state_q == ST_WAIT) & ~move_s};
      perf_flushes_q <= perf_flushes_q + {31'd0, flush_s};
    end
  end

  assign perf_moves        = perf_moves_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flushes_q;
`endif

endmodule

// File: tb/tb_pipeline_move_ctrl.sv
// Self-checking bench for pipeline_move_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an outstanding-request model.
module tb_pipeline_move_ctrl;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ireq = 1'b0, dreq = 1'b0, iresp = 1'b0, dresp = 1'b0, freq = 1'b0;
  logic imem_issue, dmem_issue, move, flush, busy, timeout_err, spurious_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_moves, perf_stall_cycles, perf_flushes;
  int unsigned m_pm = 0, m_ps = 0, m_pf = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipeline_move_ctrl #(.TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(ireq), .dmem_req_valid(dreq),
    .imem_resp(iresp), .dmem_resp(dresp), .flush_req(freq),
    .imem_issue(imem_issue), .dmem_issue(dmem_issue),
    .move(move), .flush(flush), .busy(busy), .timeout_err(timeout_err),
`ifdef PIPE_PERF_CNT_EN
    .perf_moves(perf_moves), .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
`endif
    .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  // Reference model: is a bundle waiting, which requests still lack a response,
  // accumulated flush, cycles spent waiting, sticky errors.
  bit m_wait = 1'b0, m_need_i = 1'b0, m_need_d = 1'b0, m_fl = 1'b0;
  int m_waited = 0;
  bit m_terr = 1'b0, m_serr = 1'b0;

  function automatic bit exp_move();
    if (!m_wait) return !ireq && !dreq;
    return !(m_need_i && !iresp) && !(m_need_d && !dresp);
  endfunction

  function automatic bit exp_flush();
    if (!exp_move()) return 1'b0;
    return m_wait ? (m_fl | freq) : freq;
  endfunction

  task automatic cmp(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model advance on each clock edge (or reset)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait = 0; m_need_i = 0; m_need_d = 0; m_fl = 0; m_waited = 0; m_terr = 0; m_serr = 0;
`ifdef PIPE_PERF_CNT_EN
      m_pm = 0; m_ps = 0; m_pf = 0;
`endif
    end else begin
      bit mv;
      mv = exp_move();
`ifdef PIPE_PERF_CNT_EN
      m_pm += mv; m_pf += exp_flush(); m_ps += (m_wait && !mv);
`endif
      if (!m_wait) begin
        if (iresp || dresp) m_serr = 1;
        if (!mv) begin
          m_wait = 1; m_need_i = ireq; m_need_d = dreq; m_fl = freq; m_waited = 0;
        end
      end else begin
        if ((iresp && !m_need_i) || (dresp && !m_need_d)) m_serr = 1;
        m_waited = (m_waited + 1 > TMO) ? TMO : m_waited + 1;
        if (m_waited == TMO) m_terr = 1;
        if (mv) m_wait = 0;
        else begin
          if (iresp) m_need_i = 0;
          if (dresp) m_need_d = 0;
          m_fl = m_fl | freq;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (rst) begin
      cmp("rst_move", move, 1'b0);
      cmp("rst_flush", flush, 1'b0);
      cmp("rst_busy", busy, 1'b0);
      cmp("rst_terr", timeout_err, 1'b0);
      cmp("rst_serr", spurious_err, 1'b0);
    end else begin
      cmp("imem_issue", imem_issue, !m_wait && ireq);
      cmp("dmem_issue", dmem_issue, !m_wait && dreq);
      cmp("move", move, exp_move());
      cmp("flush", flush, exp_flush());
      cmp("busy", busy, m_wait);
      cmp("timeout_err", timeout_err, m_terr);
      cmp("spurious_err", spurious_err, m_serr);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic i, input logic d, input logic ir, input logic dr, input logic f);
    ireq = i; dreq = d; iresp = ir; dresp = dr; freq = f;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;

    // Single fetch answered three cycles after issue
    drive(1, 0, 0, 0, 0); probe();
    cmp("t1_issue_c0", imem_issue, 1'b1);
    cmp("t1_move_c0", move, 1'b0);
    tick(); drive(0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 1, 0, 0); probe();
    cmp("t1_move_c3", move, 1'b1);
    tick(); drive(1, 0, 0, 0, 0); probe();
    cmp("t1_issue_c4", imem_issue, 1'b1);
    tick(); drive(0, 0, 1, 0, 0); tick();

    // Both requests, dmem answers at 2, imem at 5
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0); probe();
    cmp("t2_move_c2", move, 1'b0);
    tick(); drive(0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 1, 0, 0); probe();
    cmp("t2_move_c5", move, 1'b1);
    tick(); drive(0, 0, 0, 0, 0); probe();
    cmp("t2_no_spur", spurious_err, 1'b0);

    // Both requests, both answered in cycle 1
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0); probe();
    cmp("t3_move_c1", move, 1'b1);
    tick();

    // Empty bundles advance every cycle
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      probe();
      cmp("t4_move", move, 1'b1);
      cmp("t4_issue", imem_issue | dmem_issue, 1'b0);
      cmp("t4_busy", busy, 1'b0);
      tick();
    end

    // Flush requested mid-wait lands on the move cycle only
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); probe();
    cmp("t5_flush_move", flush & move, 1'b1);
    tick(); drive(0, 0, 0, 0, 0); probe();
    cmp("t5_flush_after", flush, 1'b0);
    tick();

    // Response with nothing outstanding
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0); probe();
    cmp("t6_spur", spurious_err, 1'b1);

    // Hung fetch raises timeout after TMO wait cycles
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int c = 1; c <= TMO + 1; c++) begin
      probe();
      cmp("t7_terr", timeout_err, (c > TMO) ? 1'b1 : 1'b0);
      cmp("t7_move", move, 1'b0);
      tick();
    end

    // Reset mid-wait clears everything at once; late response is then spurious
    rst = 1'b1; #1;
    cmp("t8_busy", busy, 1'b0);
    cmp("t8_terr", timeout_err, 1'b0);
    cmp("t8_move", move | flush | imem_issue | dmem_issue, 1'b0);
    tick(); tick(); rst = 1'b0;
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0); probe();
    cmp("t8_late_spur", spurious_err, 1'b1);

    // Randomized traffic with periodic resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 400 == 399) do_reset();
      ireq  = ($urandom_range(0, 3) != 0);
      dreq  = ($urandom_range(0, 1) != 0);
      freq  = ($urandom_range(0, 5) == 0);
      iresp = (m_wait && m_need_i && $urandom_range(0, 2) == 0) || ($urandom_range(0, 60) == 0);
      dresp = (m_wait && m_need_d && $urandom_range(0, 2) == 0) || ($urandom_range(0, 60) == 0);
      tick();
    end

`ifdef PIPE_PERF_CNT_EN
    drive(0, 0, 0, 0, 0); probe();
    n_checks++;
    if (perf_moves !== m_pm || perf_stall_cycles !== m_ps || perf_flushes !== m_pf) begin
      n_errors++;
      $display("FAIL perf got %0d/%0d/%0d expected %0d/%0d/%0d",
               perf_moves, perf_stall_cycles, perf_flushes, m_pm, m_ps, m_pf);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
